// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and constants for the instruction fetch stage
package fetch_pkg;
    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] RESET_PC_DEFAULT  = 32'h0000_0000;
    localparam logic [XLEN-1:0] NOP_INSTR_DEFAULT = 32'h0000_0013;

    typedef enum logic [1:0] {
        FETCH   = 2'd0,
        WAIT    = 2'd1,
        BLOCKED = 2'd2
    } fetch_state_t;
endpackage

// File: rtl/fetch_skid_buffer.sv
// rtl/fetch_skid_buffer.sv - one-entry {instr, pc} holding register behind the IF/ID output
module fetch_skid_buffer
    import fetch_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            load,
    input  logic            drain,
    input  logic            flush,
    input  logic [XLEN-1:0] load_instr,
    input  logic [XLEN-1:0] load_pc,
    output logic            valid,
    output logic [XLEN-1:0] instr,
    output logic [XLEN-1:0] pc
);
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid <= 1'b0;
            instr <= '0;
            pc    <= '0;
        end else begin
            if (flush)
                valid <= 1'b0;
            else if (load)
                valid <= 1'b1;
            else if (drain)
                valid <= 1'b0;
            if (load && !flush) begin
                instr <= load_instr;
                pc    <= load_pc;
            end
        end
    end
endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - PC, single-outstanding imem request FSM and registered IF/ID output
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC  = RESET_PC_DEFAULT,
    parameter logic [XLEN-1:0] NOP_INSTR = NOP_INSTR_DEFAULT
)(
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic [XLEN-1:0] imem_rdata,
    input  logic            imem_valid,
    input  logic            stall,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            instr_valid,
    output logic [XLEN-1:0] instr_out,
    output logic [XLEN-1:0] pc_out,
    output logic [XLEN-1:0] pc_plus4_out
);
    fetch_state_t    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d, fetch_addr_q;
    logic            req_q, drop_q, drop_d;
    logic            valid_q;
    logic [XLEN-1:0] instr_q, pc_out_q;

    logic            rsp, outstanding;
    logic            out_load, out_clear, out_from_skid;
    logic            skid_load, skid_drain, skid_flush, skid_valid;
    logic [XLEN-1:0] skid_instr, skid_pc;

    assign rsp         = (state_q == WAIT) && imem_valid;
    assign outstanding = req_q && !rsp;

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        drop_d        = drop_q;
        out_load      = 1'b0;
        out_clear     = 1'b0;
        out_from_skid = 1'b0;
        skid_load     = 1'b0;
        skid_drain    = 1'b0;
        skid_flush    = 1'b0;
        if (redirect_valid) begin
            pc_d       = redirect_pc & ~32'h3;
            out_clear  = 1'b1;
            skid_flush = 1'b1;
            // A request already seen by memory will still answer; swallow exactly that one.
            drop_d     = outstanding;
            state_d    = outstanding ? WAIT : FETCH;
        end else begin
            case (state_q)
                FETCH: if (req_q) state_d = WAIT;
                WAIT: begin
                    if (rsp) begin
                        if (drop_q) begin
                            drop_d  = 1'b0;
                            state_d = FETCH;
                        end else begin
                            pc_d = pc_q + 32'd4;
                            if (!valid_q || !stall) begin
                                out_load = 1'b1;
                                state_d  = FETCH;
                            end else begin
                                skid_load = 1'b1;
                                state_d   = BLOCKED;
                            end
                        end
                    end
                end
                BLOCKED: state_d = BLOCKED;
                default: state_d = FETCH;
            endcase
            if (valid_q && !stall && !out_load) begin
                if (skid_valid) begin
                    out_from_skid = 1'b1;
                    skid_drain    = 1'b1;
                    state_d       = FETCH;
                end else begin
                    out_clear = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= FETCH;
            pc_q         <= RESET_PC;
            fetch_addr_q <= RESET_PC;
            req_q        <= 1'b0;
            drop_q       <= 1'b0;
            valid_q      <= 1'b0;
            instr_q      <= NOP_INSTR;
            pc_out_q     <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            drop_q  <= drop_d;
            req_q   <= (state_d != BLOCKED);
            // The address only moves when a fresh request starts, so it stays stable while pending.
            if (state_d == FETCH)
                fetch_addr_q <= pc_d;
            if (out_clear) begin
                valid_q <= 1'b0;
                instr_q <= NOP_INSTR;
            end else if (out_load) begin
                valid_q  <= 1'b1;
                instr_q  <= imem_rdata;
                pc_out_q <= fetch_addr_q;
            end else if (out_from_skid) begin
                valid_q  <= 1'b1;
                instr_q  <= skid_instr;
                pc_out_q <= skid_pc;
            end
        end
    end

    fetch_skid_buffer u_skid (
        .clk        (clk),
        .rst        (rst),
        .load       (skid_load),
        .drain      (skid_drain),
        .flush      (skid_flush),
        .load_instr (imem_rdata),
        .load_pc    (fetch_addr_q),
        .valid      (skid_valid),
        .instr      (skid_instr),
        .pc         (skid_pc)
    );

    assign imem_req     = req_q;
    assign imem_addr    = fetch_addr_q;
    assign instr_valid  = valid_q;
    assign instr_out    = instr_q;
    assign pc_out       = pc_out_q;
    assign pc_plus4_out = pc_out_q + 32'd4;
endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - randomized self-checking bench for fetch_unit against a stream-level model
module tb_fetch_unit;
    import fetch_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req, imem_valid, stall, redirect_valid, instr_valid;
    logic [31:0] imem_addr, imem_rdata, redirect_pc, instr_out, pc_out, pc_plus4_out;

    fetch_unit dut (
        .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rdata(imem_rdata), .imem_valid(imem_valid), .stall(stall),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .instr_valid(instr_valid), .instr_out(instr_out), .pc_out(pc_out),
        .pc_plus4_out(pc_plus4_out)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int consumed = 0;
    int lat = 1;
    logic        m_pend, m_stale;
    int          m_cnt;
    logic [31:0] m_addr, exp_fetch, exp_stream;
    logic [31:0] req_log[$];
    logic [31:0] out_pc[$], out_instr[$], out_p4[$];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0) return 32'h0050_0093;
        if (a == 32'h4) return 32'h0010_0113;
        return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_pend = 1'b0; m_stale = 1'b0; m_cnt = 0; m_addr = '0;
        exp_fetch = RESET_PC_DEFAULT; exp_stream = RESET_PC_DEFAULT;
        req_log.delete(); out_pc.delete(); out_instr.delete(); out_p4.delete();
    endtask

    // One clock cycle: memory model, per-cycle output rules, then post-edge expectations.
    task automatic step();
        logic        rsp, redir, exp_lat, exp_blk, frz;
        logic        s_v;
        logic [31:0] s_instr, s_pc, s_p4, s_addr;
        if (!m_pend && imem_req) begin
            chk("req_addr", imem_addr, exp_fetch);
            req_log.push_back(imem_addr);
            m_pend = 1'b1; m_addr = imem_addr; m_cnt = lat; m_stale = 1'b0;
        end else if (m_pend) begin
            chk("req_held", 32'(imem_req), 32'd1);
            chk("addr_stable", imem_addr, m_addr);
        end
        rsp = m_pend && (m_cnt == 0);
        imem_valid = rsp;
        imem_rdata = rsp ? mem_word(m_addr) : $urandom;
        if (instr_valid) begin
            chk("instr_matches_mem", instr_out, mem_word(pc_out));
            chk("pc_plus4", pc_plus4_out, pc_out + 32'd4);
        end else begin
            chk("bubble_nop", instr_out, NOP_INSTR_DEFAULT);
        end
        redir = redirect_valid;
        if (instr_valid && !stall && !redir) begin
            chk("stream_pc", pc_out, exp_stream);
            out_pc.push_back(pc_out); out_instr.push_back(instr_out); out_p4.push_back(pc_plus4_out);
            exp_stream = exp_stream + 32'd4;
            consumed++;
        end
        exp_lat = 1'b0; exp_blk = 1'b0;
        frz = instr_valid && stall && !redir;
        s_v = instr_valid; s_instr = instr_out; s_pc = pc_out; s_p4 = pc_plus4_out; s_addr = m_addr;
        if (redir) begin
            exp_fetch = redirect_pc & ~32'h3;
            exp_stream = exp_fetch;
            if (m_pend && !rsp) m_stale = 1'b1;
        end else if (rsp && !m_stale) begin
            exp_fetch = m_addr + 32'd4;
            if (!instr_valid || !stall) exp_lat = 1'b1;
            else exp_blk = 1'b1;
        end
        @(posedge clk); #1;
        if (rsp) m_pend = 1'b0;
        else if (m_pend) m_cnt--;
        if (redir) chk("redirect_squash", 32'(instr_valid), 32'd0);
        if (frz) begin
            chk("stall_valid", 32'(instr_valid), 32'(s_v));
            chk("stall_instr", instr_out, s_instr);
            chk("stall_pc", pc_out, s_pc);
            chk("stall_pc4", pc_plus4_out, s_p4);
        end
        if (exp_lat) begin
            chk("lat_valid", 32'(instr_valid), 32'd1);
            chk("lat_pc", pc_out, s_addr);
        end
        if (exp_blk) chk("blocked_no_req", 32'(imem_req), 32'd0);
    endtask

    initial begin
        logic ok;
        int   n;
        stall = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
        imem_valid = 1'b0; imem_rdata = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", 32'(instr_valid), 32'd0);
        chk("rst_instr", instr_out, 32'h0000_0013);
        chk("rst_pc", pc_out, 32'h0);
        chk("rst_pc4", pc_plus4_out, 32'h4);
        chk("rst_req", 32'(imem_req), 32'd0);
        rst = 1'b0;

        // Basic stream, 1-cycle memory, then a 4-cycle stall that fills the skid.
        ok = 1'b0;
        for (int i = 0; i < 30 && !ok; i++) begin
            step();
            ok = instr_valid && (pc_out == 32'h4);
        end
        chk("t1_reach_pc4", 32'(ok), 32'd1);
        stall = 1'b1;
        repeat (4) step();
        chk("t2_frozen_pc", pc_out, 32'h4);
        chk("t2_frozen_instr", instr_out, 32'h0010_0113);
        chk("t2_req_low", 32'(imem_req), 32'd0);
        stall = 1'b0;
        step();
        chk("t2_skid_valid", 32'(instr_valid), 32'd1);
        chk("t2_skid_pc", pc_out, 32'h8);
        chk("t2_skid_pc4", pc_plus4_out, 32'hC);
        n = 0;
        while (req_log.size() < 4 && n < 20) begin step(); n++; end
        chk("t1_req_count", 32'(req_log.size() >= 4), 32'd1);
        chk("t1_req0", req_log[0], 32'h0);
        chk("t1_req1", req_log[1], 32'h4);
        chk("t1_req2", req_log[2], 32'h8);
        chk("t2_req3", req_log[3], 32'hC);
        chk("t1_out0_pc", out_pc[0], 32'h0);
        chk("t1_out0_instr", out_instr[0], 32'h0050_0093);
        chk("t1_out0_pc4", out_p4[0], 32'h4);
        chk("t1_out1_pc", out_pc[1], 32'h4);
        chk("t1_out1_instr", out_instr[1], 32'h0010_0113);
        chk("t1_out1_pc4", out_p4[1], 32'h8);

        // Redirect with a 3-cycle request outstanding.
        lat = 3; n = 0;
        while (!((imem_req && !m_pend) || (m_pend && m_cnt != 0)) && n < 20) begin step(); n++; end
        chk("t3_outstanding", 32'((imem_req && !m_pend) || (m_pend && m_cnt != 0)), 32'd1);
        redirect_valid = 1'b1; redirect_pc = 32'h100;
        step();
        redirect_valid = 1'b0;
        req_log.delete(); n = 0;
        while (req_log.size() == 0 && n < 20) begin step(); n++; end
        chk("t3_new_req", req_log[0], 32'h100);
        n = 0;
        while (!instr_valid && n < 20) begin step(); n++; end
        chk("t3_first_pc", pc_out, 32'h100);

        // Redirect coincident with a response, unaligned target.
        lat = 2; n = 0;
        while (!(m_pend && m_cnt == 0) && n < 20) begin step(); n++; end
        chk("t4_resp_cycle", 32'(m_pend && m_cnt == 0), 32'd1);
        redirect_valid = 1'b1; redirect_pc = 32'h203;
        step();
        redirect_valid = 1'b0;
        chk("t4_addr", imem_addr, 32'h200);
        chk("t4_req", 32'(imem_req), 32'd1);

        // Address wrap past the top of memory.
        lat = 1;
        redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        step();
        redirect_valid = 1'b0;
        req_log.delete(); n = 0;
        while (req_log.size() < 2 && n < 30) begin step(); n++; end
        chk("t5_top", req_log[0], 32'hFFFF_FFFC);
        chk("t5_wrap", req_log[1], 32'h0);

        // Asynchronous reset while blocked with the skid full.
        stall = 1'b1; n = 0;
        while (!(instr_valid && !imem_req) && n < 30) begin step(); n++; end
        chk("t6_blocked", 32'(instr_valid && !imem_req), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("t6_rst_valid", 32'(instr_valid), 32'd0);
        chk("t6_rst_instr", instr_out, 32'h0000_0013);
        chk("t6_rst_req", 32'(imem_req), 32'd0);
        imem_valid = 1'b0; stall = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
        n = 0;
        while (req_log.size() == 0 && n < 10) begin step(); n++; end
        chk("t6_first_req", req_log[0], RESET_PC_DEFAULT);

        // Randomized traffic checked by the model on every cycle.
        consumed = 0;
        for (int i = 0; i < 3000; i++) begin
            stall = ($urandom % 10) < 3;
            redirect_valid = ($urandom % 20) == 0;
            redirect_pc = $urandom;
            lat = $urandom_range(1, 4);
            step();
        end
        redirect_valid = 1'b0; stall = 1'b0;
        chk("rand_progress", 32'(consumed > 100), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
